// File: rtl/sys_reset_ctrl_if.sv
// rtl/sys_reset_ctrl_if.sv - reset controller board/CPU/system signal bundle
//
// Purpose: groups the non-clock signals of sys_reset_ctrl.
//   master : the environment. It drives pll_lock, button_n and soft_req.
//   slave  : the reset controller. It drives sys_reset, sys_ready and reset_cause.
// Signals:
//   pll_lock    - PLL LOCK pin, asynchronous
//   button_n    - board reset button, active-low, asynchronous, bouncy
//   soft_req    - one-cycle synchronous soft-reset request from the CPU
//   sys_reset   - active-high system reset
//   sys_ready   - high only while the system runs
//   reset_cause - 00 POR, 01 LOCK, 10 BUTTON, 11 SOFT
interface sys_reset_ctrl_if;
  logic       pll_lock;
  logic       button_n;
  logic       soft_req;
  logic       sys_reset;
  logic       sys_ready;
  logic [1:0] reset_cause;

  modport master (
    output pll_lock, button_n, soft_req,
    input  sys_reset, sys_ready, reset_cause
  );

  modport slave (
    input  pll_lock, button_n, soft_req,
    output sys_reset, sys_ready, reset_cause
  );
endinterface

// File: rtl/sys_reset_ctrl.sv
// rtl/sys_reset_ctrl.sv - system reset sequencer: PLL lock filter, hold timer, button/soft reset
//
// Purpose: keeps the SoC in reset until the PLL lock is stable. It then holds reset
// for HOLD_CYCLES and releases it on a clock edge. Loss of lock, a debounced button
// press or a CPU soft request re-enters reset.
// Ports:
//   clock - PLL output clock
//   reset - asynchronous active-high power-on/board reset
//   bus   - sys_reset_ctrl_if.slave (pll_lock, button_n, soft_req in;
//           sys_reset, sys_ready, reset_cause out)
// Optional feature: define SYS_RESET_CAUSE_EN to build the reset_cause register.
// When it is not defined, reset_cause is tied to 2'b00.
module sys_reset_ctrl #(
  parameter int LOCK_FILTER     = 16,
  parameter int HOLD_CYCLES     = 1024,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic            clock,
  input  logic            reset,
  sys_reset_ctrl_if.slave bus
);
  localparam int LF_W = $clog2(LOCK_FILTER + 1);
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [LF_W-1:0] LF_MAX    = LF_W'(LOCK_FILTER);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_WAIT_LOCK    = 2'd0;
  localparam logic [1:0] ST_HOLD         = 2'd1;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN          = 2'd3;

  logic            lock_s1, lock_s;
  logic            btn_s1, btn_s;
  logic            btn_db, btn_db_nxt;
  logic [DB_W-1:0] db_cnt, db_cnt_nxt;
  logic [LF_W-1:0] lock_cnt, lock_cnt_nxt;
  logic            lock_ok;
  logic [1:0]      state, state_nxt;
  logic [HC_W-1:0] hold_cnt, hold_cnt_nxt;
  logic            sys_reset_q, sys_ready_q;

  // The button is inverted ahead of the synchronizer, so btn_s means "pressed".
  // A zero reset value then reads as "released".
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_s1 <= 1'b0;
      lock_s  <= 1'b0;
      btn_s1  <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      lock_s1 <= bus.pll_lock;
      lock_s  <= lock_s1;
      btn_s1  <= ~bus.button_n;
      btn_s   <= btn_s1;
    end
  end

  // Debouncer. The counter measures how long btn_s has disagreed with btn_db.
  always_comb begin
    btn_db_nxt = btn_db;
    db_cnt_nxt = '0;
    if (btn_s != btn_db) begin
      if (db_cnt == DB_LAST) btn_db_nxt = btn_s;
      else                   db_cnt_nxt = db_cnt + 1'b1;
    end
  end

  // Lock filter. It saturates at LOCK_FILTER and clears whenever lock is low.
  always_comb begin
    lock_cnt_nxt = '0;
    if (lock_s) lock_cnt_nxt = (lock_cnt == LF_MAX) ? lock_cnt : lock_cnt + 1'b1;
  end

  // The FSM decides on the edge where the filter or debouncer reaches its
  // threshold. It therefore looks at the next-state values, not the registered ones.
  assign lock_ok = (lock_cnt_nxt == LF_MAX);

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = '0;
    case (state)
      ST_WAIT_LOCK: begin
        if (lock_ok) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!lock_s)                    state_nxt = ST_WAIT_LOCK;
        else if (btn_db_nxt)            state_nxt = ST_WAIT_RELEASE;
        else if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
        else                            hold_cnt_nxt = hold_cnt + 1'b1;
      end
      ST_WAIT_RELEASE: begin
        if (!lock_s)                     state_nxt = ST_WAIT_LOCK;
        else if (!btn_db_nxt && lock_ok) state_nxt = ST_HOLD;
      end
      default: begin
        if (!lock_s)          state_nxt = ST_WAIT_LOCK;
        else if (btn_db_nxt)  state_nxt = ST_WAIT_RELEASE;
        else if (bus.soft_req) state_nxt = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_db      <= 1'b0;
      db_cnt      <= '0;
      lock_cnt    <= '0;
      state       <= ST_WAIT_LOCK;
      hold_cnt    <= '0;
      sys_reset_q <= 1'b1;
      sys_ready_q <= 1'b0;
    end else begin
      btn_db      <= btn_db_nxt;
      db_cnt      <= db_cnt_nxt;
      lock_cnt    <= lock_cnt_nxt;
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      sys_reset_q <= (state_nxt != ST_RUN);
      sys_ready_q <= (state_nxt == ST_RUN);
    end
  end

  assign bus.sys_reset = sys_reset_q;
  assign bus.sys_ready = sys_ready_q;

`ifdef SYS_RESET_CAUSE_EN
  logic [1:0] cause_q;
  logic [1:0] cause_nxt;

  // The cause is taken only on the edge that leaves RUN. The target state tells
  // which event won the priority order.
  always_comb begin
    cause_nxt = cause_q;
    if (state == ST_RUN && state_nxt != ST_RUN) begin
      case (state_nxt)
        ST_WAIT_LOCK:    cause_nxt = 2'b01;
        ST_WAIT_RELEASE: cause_nxt = 2'b10;
        default:         cause_nxt = 2'b11;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cause_q <= 2'b00;
    else       cause_q <= cause_nxt;
  end

  assign bus.reset_cause = cause_q;
`else
  assign bus.reset_cause = 2'b00;
`endif

endmodule

// File: tb/tb_sys_reset_ctrl.sv
// tb/tb_sys_reset_ctrl.sv - directed and random bench for sys_reset_ctrl against a behavioural model
module tb_sys_reset_ctrl;
  localparam int LF = 4;
  localparam int HC = 8;
  localparam int DC = 5;

`ifdef SYS_RESET_CAUSE_EN
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_BTN  = 2'b10;
  localparam logic [1:0] CAUSE_SOFT = 2'b11;
`else
  localparam logic [1:0] CAUSE_LOCK = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b00;
  localparam logic [1:0] CAUSE_SOFT = 2'b00;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  sys_reset_ctrl_if bus ();

  sys_reset_ctrl #(
    .LOCK_FILTER(LF),
    .HOLD_CYCLES(HC),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: run lengths and a countdown, stepped once per clock edge
  typedef enum {M_WAIT, M_HOLD, M_REL, M_RUN} phase_t;
  phase_t     ph;
  int         hold_left, lock_run, diff_run;
  bit         m_l1, m_ls, m_b1, m_bs, m_db;
  logic [1:0] m_cause;

  task automatic model_reset();
    ph = M_WAIT; hold_left = 0; lock_run = 0; diff_run = 0;
    m_l1 = 0; m_ls = 0; m_b1 = 0; m_bs = 0; m_db = 0; m_cause = 2'b00;
  endtask

  function automatic logic [1:0] exp_cause();
`ifdef SYS_RESET_CAUSE_EN
    return m_cause;
`else
    return 2'b00;
`endif
  endfunction

  task automatic model_step();
    int run_n, dr;
    bit ok, db_n;
    if (reset) begin
      model_reset();
      return;
    end
    run_n = m_ls ? lock_run + 1 : 0;
    if (run_n > LF) run_n = LF;
    ok = (run_n >= LF);
    db_n = m_db;
    dr = 0;
    if (m_bs != m_db) begin
      dr = diff_run + 1;
      if (dr >= DC) begin
        db_n = m_bs;
        dr = 0;
      end
    end
    case (ph)
      M_WAIT: if (ok) begin ph = M_HOLD; hold_left = HC; end
      M_HOLD: begin
        if (!m_ls) ph = M_WAIT;
        else if (db_n) ph = M_REL;
        else begin
          hold_left--;
          if (hold_left == 0) ph = M_RUN;
        end
      end
      M_REL: begin
        if (!m_ls) ph = M_WAIT;
        else if (!db_n && ok) begin ph = M_HOLD; hold_left = HC; end
      end
      default: begin
        if (!m_ls) begin ph = M_WAIT; m_cause = 2'b01; end
        else if (db_n) begin ph = M_REL; m_cause = 2'b10; end
        else if (bus.soft_req) begin ph = M_HOLD; hold_left = HC; m_cause = 2'b11; end
      end
    endcase
    lock_run = run_n; m_db = db_n; diff_run = dr;
    m_ls = m_l1; m_l1 = bus.pll_lock;
    m_bs = m_b1; m_b1 = !bus.button_n;
  endtask

  // One clock: the model steps on the edge and the outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("sys_reset", bus.sys_reset, ph != M_RUN);
    chk("sys_ready", bus.sys_ready, ph == M_RUN);
    chk("reset_cause", bus.reset_cause, exp_cause());
  endtask

  task automatic count_to_fall(input string tag, input int exp_edges);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.sys_reset && n < 200);
    chk(tag, n, exp_edges);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("async_reset", bus.sys_reset, 1);
    chk("async_ready", bus.sys_ready, 0);
    model_reset();
  endtask

  initial begin
    int n, acc;
    bus.pll_lock = 1'b1; bus.button_n = 1'b1; bus.soft_req = 1'b0;
    model_reset();
    repeat (3) tick();

    // power-up with lock already high
    reset = 1'b0;
    count_to_fall("powerup_edges", 14);
    chk("powerup_ready", bus.sys_ready, 1);
    chk("powerup_cause", bus.reset_cause, 0);

    // glitchy lock
    bus.pll_lock = 1'b0;
    do_reset();
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    bus.pll_lock = 1'b1; repeat (3) tick();
    bus.pll_lock = 1'b0; repeat (2) tick();
    bus.pll_lock = 1'b1;
    count_to_fall("glitch_edges", 14);

    // soft reset
    repeat (3) tick();
    bus.soft_req = 1'b1; tick(); bus.soft_req = 1'b0;
    chk("soft_rise", bus.sys_reset, 1);
    n = 1;
    do begin
      tick();
      if (bus.sys_reset) n++;
    end while (bus.sys_reset && n < 100);
    chk("soft_high_cycles", n, HC);
    chk("soft_cause", bus.reset_cause, CAUSE_SOFT);

    // button bounce, then a real press
    bus.button_n = 1'b0; repeat (3) tick(); bus.button_n = 1'b1;
    acc = 0;
    repeat (10) begin tick(); acc = acc | 32'(bus.sys_reset); end
    chk("bounce_ignored", acc, 0);
    bus.button_n = 1'b0; repeat (20) tick();
    chk("press_reset", bus.sys_reset, 1);
    chk("press_ready", bus.sys_ready, 0);
    bus.button_n = 1'b1;
    count_to_fall("button_edges", 2 + DC + HC);
    chk("button_cause", bus.reset_cause, CAUSE_BTN);

    // lock loss together with a soft request
    repeat (2) tick();
    bus.pll_lock = 1'b0;
    repeat (2) tick();
    chk("lockdrop_edge2", bus.sys_reset, 0);
    bus.soft_req = 1'b1; tick(); bus.soft_req = 1'b0;
    chk("simul_reset", bus.sys_reset, 1);
    chk("simul_cause", bus.reset_cause, CAUSE_LOCK);
    bus.pll_lock = 1'b1;
    count_to_fall("relock_edges", 14);

    // reset asserted mid-HOLD
    do_reset();
    tick();
    reset = 1'b0;
    repeat (8) tick();
    chk("mid_hold_reset", bus.sys_reset, 1);
    do_reset();
    tick();
    reset = 1'b0;
    count_to_fall("rerun_edges", 14);
    chk("rerun_cause", bus.reset_cause, 0);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if (bus.pll_lock) begin
        if ($urandom_range(99) < 2) bus.pll_lock = 1'b0;
      end else if ($urandom_range(99) < 25) bus.pll_lock = 1'b1;
      if (bus.button_n) begin
        if ($urandom_range(99) < 3) bus.button_n = 1'b0;
      end else if ($urandom_range(99) < 12) bus.button_n = 1'b1;
      bus.soft_req = ($urandom_range(99) < 8);
      if ($urandom_range(999) < 4) begin
        do_reset();
        tick();
        reset = 1'b0;
      end
      tick();
    end
    bus.soft_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
